// File: rtl/pwm_capture32_pkg.sv
// Shared types and constants for the 32-bit PWM capture block.
package pwm_cap_pkg;

   localparam int                CNT_W   = 32;
   localparam logic [CNT_W-1:0]  CNT_MAX = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      IDLE,
      ARM,
      HIGH,
      LOW
   } state_t;

endpackage

// File: rtl/pwm_capture32_if.sv
// Control and result signals of the PWM capture block.
// The slave side is the capture block itself; the master side is its user.
interface pwm_capture32_if;
   import pwm_cap_pkg::*;

   logic             en;
   logic             pwm_in;
   logic             inv;
   logic [3:0]       clkdiv;
   logic [CNT_W-1:0] timeout;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] high_time;
   logic             valid;
   logic             timeout_flag;
   logic             level;

   modport master (
      output en, pwm_in, inv, clkdiv, timeout,
      input  period, high_time, valid, timeout_flag, level
   );

   modport slave (
      input  en, pwm_in, inv, clkdiv, timeout,
      output period, high_time, valid, timeout_flag, level
   );

endinterface

// File: rtl/pwm_sync.sv
// Multi-flop synchronizer bringing the asynchronous PWM input into the clk domain.
module pwm_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] stages;

   // Shift the input through the flop chain; the last stage is the safe copy.
   // NOTE: clocked state uses non-blocking (<=) so every flop samples the pre-edge value of its neighbour.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) stages <= '0;
      else     stages <= {stages[SYNC_STAGES-2:0], d};
   end

   assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/pwm_capture32.sv
// PWM capture: measures period and high time of pwm_in in prescaled ticks,
// publishes each full cycle with a one-clock valid, flags a stuck input.
module pwm_capture32
   import pwm_cap_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic           clk,
   input  logic           rst,
   pwm_capture32_if.slave bus
);

   logic             s_sync, s, s_prev;
   logic             tick, rise, fall;
   logic [3:0]       psc;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt, hi_lat, period_q, high_q;
   logic             valid_q, tflag_q, level_q;
   logic             timeout_hit, publish, capture_hi, to_fire;

   pwm_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (bus.pwm_in),
      .q   (s_sync)
   );

   assign s    = s_sync ^ bus.inv;
   assign tick = bus.en && (psc == bus.clkdiv);
   assign rise = tick && s && !s_prev;
   assign fall = tick && !s && s_prev;

   // An edge on the same tick wins over the timeout.
   assign timeout_hit = tick && (bus.timeout != '0) && (cnt == bus.timeout) && !rise && !fall;

   // Prescaler: counts clocks up to clkdiv, held at zero while disabled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                    psc <= '0;
      else if (!bus.en || tick)   psc <= '0;
      else                        psc <= psc + 4'd1;
   end

   // Previous tick-sampled level; tracks s in IDLE so arming never sees a false edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                           s_prev <= 1'b0;
      else if (tick || state_q == IDLE)  s_prev <= s;
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next state and per-cycle event strobes.
   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d    = state_q;
      publish    = 1'b0;
      capture_hi = 1'b0;
      to_fire    = 1'b0;
      if (!bus.en) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: state_d = ARM;
            ARM: begin
               if (rise) state_d = HIGH;
               else if (timeout_hit) to_fire = 1'b1;
            end
            HIGH: begin
               if (fall) begin
                  state_d    = LOW;
                  capture_hi = 1'b1;
               end else if (timeout_hit) begin
                  state_d = ARM;
                  to_fire = 1'b1;
               end
            end
            LOW: begin
               if (rise) begin
                  state_d = HIGH;
                  publish = 1'b1;
               end else if (timeout_hit) begin
                  state_d = ARM;
                  to_fire = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Tick counter: cleared when arming, restarted at 1 on a rise, saturating otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (bus.en) begin
         if (state_q == IDLE || to_fire)    cnt <= '0;
         else if (rise)                     cnt <= CNT_W'(1);
         else if (tick && cnt != CNT_MAX)   cnt <= cnt + CNT_W'(1);
      end
   end

   // Result registers, valid strobe and sticky timeout indication.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hi_lat   <= '0;
         period_q <= '0;
         high_q   <= '0;
         valid_q  <= 1'b0;
         tflag_q  <= 1'b0;
         level_q  <= 1'b0;
      end else begin
         valid_q <= publish;
         if (capture_hi) hi_lat <= cnt;
         if (publish) begin
            period_q <= cnt;
            high_q   <= hi_lat;
         end
         if (!bus.en || publish) tflag_q <= 1'b0;
         else if (to_fire)       tflag_q <= 1'b1;
         if (to_fire) level_q <= s;
      end
   end

   assign bus.period       = period_q;
   assign bus.high_time    = high_q;
   assign bus.valid        = valid_q;
   assign bus.timeout_flag = tflag_q;
   assign bus.level        = level_q;

endmodule
